// File: rtl/ascii_value_formatter.sv
// ascii_value_formatter
// Converts a binary parameter value into a right-justified ASCII string for the
// on-screen text sprite renderers. Conversion is sequential double-dabble
// (one shift-add-3 step per clock) followed by one formatting step that inserts
// the sign, blanks leading zeros and detects overflow.
//
// Ports:
//   Clk          system clock, rising edge
//   Reset_n      asynchronous active-low reset
//   start        request conversion of value_in (sampled only when idle)
//   value_in     value to format, captured on the accepting edge
//   busy         high from the accepting edge through the load_string cycle
//   load_string  one-cycle strobe, string_out valid in that cycle
//   string_out   ASCII string, leftmost character in the top byte
module ascii_value_formatter #(
  parameter int unsigned VALUE_W   = 10,
  parameter int unsigned SIGNED    = 1,
  parameter int unsigned NUM_CHARS = 4
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   start,
  input  logic [VALUE_W-1:0]     value_in,
  output logic                   busy,
  output logic                   load_string,
  output logic [8*NUM_CHARS-1:0] string_out
);

  // Decimal digits needed for VALUE_W bits: ceil(VALUE_W*log10(2)) + 1.
  // The fixed-point constant is rounded up, so it can only overestimate.
  function automatic int unsigned bcd_digits(input int unsigned w);
    return ((w * 30103) + 99999) / 100000 + 1;
  endfunction

  localparam int unsigned BCD_D = bcd_digits(VALUE_W);
  localparam int unsigned BCD_W = 4 * BCD_D;
  localparam int unsigned STR_W = 8 * NUM_CHARS;
  localparam int unsigned CNT_W = $clog2(VALUE_W + 1);
  localparam int          DIG   = int'(NUM_CHARS) - int'(SIGNED);
  localparam int          NCH   = int'(NUM_CHARS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FORMAT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 load_q, load_d;
  logic [STR_W-1:0]     str_q, str_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [VALUE_W-1:0]   mag_q, mag_d;
  logic                 sign_q, sign_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 value_neg;
  logic [VALUE_W-1:0]   value_abs;
  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W+VALUE_W-1:0] shift_next;
  logic [STR_W-1:0]     str_fmt;
  logic                 any_nz;
  logic                 ovf;
  int                   msd;

  // Sign and magnitude of the incoming value. A VALUE_W-bit negate is exact
  // here: the most negative magnitude 2^(VALUE_W-1) still fits unsigned.
  always_comb begin
    value_neg = (SIGNED != 0) && value_in[VALUE_W-1];
    value_abs = value_neg ? ((~value_in) + VALUE_W'(1)) : value_in;
  end

  // Double-dabble step: add 3 to every digit >= 5, then shift {bcd, mag}.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(BCD_D); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shift_next = {bcd_adj, mag_q} << 1;
  end

  // Final string from the finished BCD register and captured sign.
  always_comb begin
    str_fmt = {NUM_CHARS{8'h20}};
    any_nz  = 1'b0;
    ovf     = 1'b0;
    msd     = 0;
    for (int i = 0; i < int'(BCD_D); i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) begin
        any_nz = 1'b1;
        msd    = i;
        if (i >= DIG) begin
          ovf = 1'b1;
        end
      end
    end
    // The minus sign needs a position left of the most significant digit.
    if (sign_q && any_nz && (msd + 1 >= NCH)) begin
      ovf = 1'b1;
    end
    if (ovf) begin
      str_fmt = {NUM_CHARS{8'h23}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if ((i <= msd) && (i < int'(BCD_D))) begin
          str_fmt[8*i +: 8] = 8'h30 + {4'h0, bcd_q[4*i +: 4]};
        end else if ((i == msd + 1) && sign_q && any_nz) begin
          str_fmt[8*i +: 8] = 8'h2D;
        end
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    load_d  = 1'b0;
    str_d   = str_q;
    bcd_d   = bcd_q;
    mag_d   = mag_q;
    sign_d  = sign_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // busy still high here means this is the load_string cycle: start ignored.
        if (busy_q) begin
          busy_d = 1'b0;
        end else if (start) begin
          sign_d  = value_neg;
          mag_d   = value_abs;
          bcd_d   = '0;
          cnt_d   = CNT_W'(VALUE_W);
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {bcd_d, mag_d} = shift_next;
        cnt_d          = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FORMAT;
        end
      end
      S_FORMAT: begin
        str_d   = str_fmt;
        load_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      load_q  <= 1'b0;
      str_q   <= {NUM_CHARS{8'h20}};
      bcd_q   <= '0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      load_q  <= load_d;
      str_q   <= str_d;
      bcd_q   <= bcd_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy        = busy_q;
  assign load_string = load_q;
  assign string_out  = str_q;

endmodule

// File: tb/tb_ascii_value_formatter.sv
// Directed testbench for ascii_value_formatter: default 4-char signed instance
// plus 2-char unsigned and 2-char signed instances for overflow behaviour.
module tb_ascii_value_formatter;

  logic        clk;
  logic        rst_n;

  logic        start_a, busy_a, load_a;
  logic [9:0]  value_a;
  logic [31:0] str_a;

  logic        start_u, busy_u, load_u;
  logic [9:0]  value_u;
  logic [15:0] str_u;

  logic        start_s, busy_s, load_s;
  logic [9:0]  value_s;
  logic [15:0] str_s;

  int n_cmp;
  int n_err;

  ascii_value_formatter #(.VALUE_W(10), .SIGNED(1), .NUM_CHARS(4)) dut (
    .Clk(clk), .Reset_n(rst_n), .start(start_a), .value_in(value_a),
    .busy(busy_a), .load_string(load_a), .string_out(str_a)
  );

  ascii_value_formatter #(.VALUE_W(10), .SIGNED(0), .NUM_CHARS(2)) dut_u2 (
    .Clk(clk), .Reset_n(rst_n), .start(start_u), .value_in(value_u),
    .busy(busy_u), .load_string(load_u), .string_out(str_u)
  );

  ascii_value_formatter #(.VALUE_W(10), .SIGNED(1), .NUM_CHARS(2)) dut_s2 (
    .Clk(clk), .Reset_n(rst_n), .start(start_s), .value_in(value_s),
    .busy(busy_s), .load_string(load_s), .string_out(str_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy_a, load_a, str_a} !== {2'b00, 32'h20202020}) begin
      n_err++;
      $display("FAIL reset_default: got busy=%b load=%b str=%h expected busy=0 load=0 str=20202020",
               busy_a, load_a, str_a);
    end
    n_cmp++;
    if ({busy_u, load_u, str_u, busy_s, load_s, str_s} !== {2'b00, 16'h2020, 2'b00, 16'h2020}) begin
      n_err++;
      $display("FAIL reset_narrow: got u=%b%b%h s=%b%b%h expected 00/2020 for both",
               busy_u, load_u, str_u, busy_s, load_s, str_s);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy_a, load_a, str_a} !== {2'b00, 32'h20202020}) begin
        n_err++;
        $display("FAIL idle_stable cycle %0d: got busy=%b load=%b str=%h expected 0 0 20202020",
                 k, busy_a, load_a, str_a);
      end
    end
  endtask

  // One conversion on the default instance: latency, strobe width, busy span, string.
  task automatic run_conv(input logic [9:0] v, input logic [31:0] exp_str, input string name);
    int first, nload, nbusy;
    logic [31:0] got;
    first = 0; nload = 0; nbusy = 0; got = 32'hxxxxxxxx;
    @(negedge clk);
    value_a = v;
    start_a = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start_a = 1'b0;
        value_a = v ^ 10'h3FF;
      end
      if (busy_a) nbusy++;
      if (load_a) begin
        nload++;
        if (first == 0) begin
          first = k;
          got   = str_a;
        end
      end
    end
    n_cmp++;
    if (got !== exp_str) begin
      n_err++;
      $display("FAIL %s string: got %h expected %h", name, got, exp_str);
    end
    n_cmp++;
    if (first != 12) begin
      n_err++;
      $display("FAIL %s latency: got strobe at cycle %0d expected 12", name, first);
    end
    n_cmp++;
    if (nload != 1) begin
      n_err++;
      $display("FAIL %s strobe_count: got %0d expected 1", name, nload);
    end
    n_cmp++;
    if (nbusy != 12) begin
      n_err++;
      $display("FAIL %s busy_cycles: got %0d expected 12", name, nbusy);
    end
  endtask

  task automatic test_values();
    run_conv(10'd0,   32'h20202030, "zero");
    run_conv(10'h200, 32'h2D353132, "neg512");
    run_conv(10'h3F9, 32'h20202D37, "neg7");
    run_conv(10'd37,  32'h20203337, "pos37");
    run_conv(10'h1FF, 32'h20353131, "pos511");
    run_conv(10'h39C, 32'h2D313030, "neg100");
  endtask

  // start held high: accepted at E0 and again one edge after busy falls (E13).
  task automatic test_back_to_back();
    int nload, first, second;
    logic prev, dbl;
    logic [31:0] s1, s2;
    nload = 0; first = 0; second = 0; prev = 1'b0; dbl = 1'b0;
    s1 = 32'hxxxxxxxx; s2 = 32'hxxxxxxxx;
    @(negedge clk);
    value_a = 10'd5;
    start_a = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 3) value_a = 10'd123;
      if (load_a) begin
        nload++;
        if (prev) dbl = 1'b1;
        if (first == 0) begin first = k; s1 = str_a; end
        else if (second == 0) begin second = k; s2 = str_a; end
      end
      prev = load_a;
      if (k == 25) start_a = 1'b0;
    end
    n_cmp++;
    if (s1 !== 32'h20202035) begin
      n_err++;
      $display("FAIL held_first string: got %h expected 20202035", s1);
    end
    n_cmp++;
    if (s2 !== 32'h20313233) begin
      n_err++;
      $display("FAIL held_second string: got %h expected 20313233", s2);
    end
    n_cmp++;
    if ((first != 12) || (second != 25)) begin
      n_err++;
      $display("FAIL held_timing: got strobes at %0d,%0d expected 12,25", first, second);
    end
    n_cmp++;
    if ((nload != 2) || dbl) begin
      n_err++;
      $display("FAIL held_strobes: got count=%0d double=%b expected 2 and 0", nload, dbl);
    end
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL held_idle busy: got %b expected 0", busy_a);
    end
  endtask

  task automatic run_narrow(input bit sgn, input logic [9:0] v, input logic [15:0] exp_str,
                            input string name);
    int first;
    logic [15:0] got;
    first = 0;
    got   = 16'hxxxx;
    @(negedge clk);
    if (sgn) begin value_s = v; start_s = 1'b1; end
    else     begin value_u = v; start_u = 1'b1; end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin start_s = 1'b0; start_u = 1'b0; end
      if (first == 0) begin
        if (sgn ? load_s : load_u) begin
          first = k;
          got   = sgn ? str_s : str_u;
        end
      end
    end
    n_cmp++;
    if ((got !== exp_str) || (first != 12)) begin
      n_err++;
      $display("FAIL %s: got str=%h at cycle %0d expected %h at cycle 12", name, got, first, exp_str);
    end
  endtask

  task automatic test_overflow();
    run_narrow(1'b0, 10'd99,  16'h3939, "u2_99");
    run_narrow(1'b0, 10'd100, 16'h2323, "u2_100");
    run_narrow(1'b0, 10'd7,   16'h2037, "u2_7");
    run_narrow(1'b1, 10'h3F1, 16'h2323, "s2_neg15");
    run_narrow(1'b1, 10'h3F9, 16'h2D37, "s2_neg7");
    run_narrow(1'b1, 10'd9,   16'h2039, "s2_9");
    run_narrow(1'b1, 10'd0,   16'h2030, "s2_0");
  endtask

  task automatic test_reset_abort();
    int nload;
    nload = 0;
    @(negedge clk);
    value_a = 10'd37;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 18; k++) begin
      if (k == 2) rst_n = 1'b1;
      @(negedge clk);
      if (load_a) nload++;
    end
    n_cmp++;
    if (nload != 0) begin
      n_err++;
      $display("FAIL abort_strobe: got %0d strobes expected 0", nload);
    end
    n_cmp++;
    if ({busy_a, str_a} !== {1'b0, 32'h20202020}) begin
      n_err++;
      $display("FAIL abort_state: got busy=%b str=%h expected 0 20202020", busy_a, str_a);
    end
    run_conv(10'h3F9, 32'h20202D37, "after_abort");
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    start_a = 1'b0; value_a = '0;
    start_u = 1'b0; value_u = '0;
    start_s = 1'b0; value_s = '0;
    test_reset();
    test_values();
    test_back_to_back();
    test_overflow();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
